// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared seven-segment constants and the hex glyph table
// Segment bytes are active-low, bit7..bit0 = a,b,c,d,e,f,g,dp.
package seg_display_pkg;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int SEG_A = 7;
    localparam int SEG_B = 6;
    localparam int SEG_C = 5;
    localparam int SEG_D = 4;
    localparam int SEG_E = 3;
    localparam int SEG_F = 2;
    localparam int SEG_G = 1;
    localparam int SEG_DP = 0;
    localparam logic [7:0] HEX_GLYPH [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_GLYPH[nibble];
    endfunction
endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: 4-bit nibble to active-low seven-segment pattern (dp off)
// Ports: nibble in 4, seg out 8 (a,b,c,d,e,f,g,dp active-low).
module seg_hex_decoder
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);
    assign seg = hex_to_seg(nibble);
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed seven-segment scanner with double-buffered load
// Ports: clk, rst (sync, active-high); wr_data/wr_dp/wr_valid/wr_ready load
// handshake; blank_mask/blink_mask/lz_suppress live controls; enable/which/seg
// registered digit-select and active-low segment outputs.
module seg_scan_display
    import seg_display_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 16384,
    parameter int BLINK_FRAMES = 32,
    localparam int WHICH_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] wr_data,
    input  logic [N_DIGITS-1:0]   wr_dp,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  lz_suppress,
    output logic                  enable,
    output logic [WHICH_W-1:0]    which,
    output logic [7:0]            seg
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Per-digit arrays are padded to a power of two so which_nxt never indexes out of range.
    localparam int NP = 1 << WHICH_W;

    logic [CNT_W-1:0]      cnt;
    logic [FR_W-1:0]       fr_cnt;
    logic                  blink_phase;
    logic [4*N_DIGITS-1:0] disp_data, pend_data, data_nxt;
    logic [N_DIGITS-1:0]   disp_dp, pend_dp, dp_nxt;
    logic                  pend_full;
    logic                  tick, last, frame_end, frame_wrap, blink_nxt, load, zero_run;
    logic [WHICH_W-1:0]    which_nxt;
    logic [3:0]            nib_arr [NP];
    logic [3:0]            nib_sel;
    logic [NP-1:0]         hide, dp_pad;
    logic [7:0]            dec_seg, seg_shown;

    assign wr_ready = ~pend_full;

    // Everything feeding seg/enable uses next-state values so the glyph
    // lands on the same edge as the digit select that shows it.
    always_comb begin
        tick = cnt == CNT_W'(SCAN_DIV - 1);
        last = which == WHICH_W'(N_DIGITS - 1);
        frame_end = tick && last;
        which_nxt = tick ? (last ? '0 : which + 1'b1) : which;
        frame_wrap = frame_end && fr_cnt == FR_W'(BLINK_FRAMES - 1);
        blink_nxt = blink_phase ^ frame_wrap;
        load = frame_end && pend_full;
        data_nxt = load ? pend_data : disp_data;
        dp_nxt = load ? pend_dp : disp_dp;
        dp_pad = NP'(dp_nxt);
        hide = '0;
        zero_run = 1'b1;
        for (int i = 0; i < NP; i++) nib_arr[i] = 4'h0;
        for (int i = 0; i < N_DIGITS; i++) begin
            nib_arr[i] = data_nxt[4*(N_DIGITS-1-i) +: 4];
            zero_run = zero_run && nib_arr[i] == 4'h0;
            hide[i] = blank_mask[i] || (blink_mask[i] && blink_nxt)
                   || (lz_suppress && zero_run && i < N_DIGITS - 1);
        end
        nib_sel = nib_arr[which_nxt];
        seg_shown = dec_seg;
        seg_shown[SEG_DP] = ~dp_pad[which_nxt];
    end

    seg_hex_decoder u_dec (
        .nibble (nib_sel),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            which <= '0;
            fr_cnt <= '0;
            blink_phase <= 1'b0;
            disp_data <= '0;
            disp_dp <= '0;
            pend_data <= '0;
            pend_dp <= '0;
            pend_full <= 1'b0;
            seg <= SEG_BLANK;
            enable <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            which <= which_nxt;
            fr_cnt <= frame_end ? (frame_wrap ? '0 : fr_cnt + 1'b1) : fr_cnt;
            blink_phase <= blink_nxt;
            disp_data <= data_nxt;
            disp_dp <= dp_nxt;
            if (load) begin
                pend_full <= 1'b0;
            end else if (wr_valid && !pend_full) begin
                pend_data <= wr_data;
                pend_dp <= wr_dp;
                pend_full <= 1'b1;
            end
            seg <= hide[which_nxt] ? SEG_BLANK : seg_shown;
            enable <= ~hide[which_nxt];
        end
    end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: self-checking bench for seg_scan_display
module tb_seg_scan_display;
    localparam int N = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FR = SD * N;
    localparam logic [7:0] HEX [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    logic clk = 1'b0;
    logic rst, rst2;
    logic [15:0] wr_data;
    logic [3:0] wr_dp, blank_mask, blink_mask;
    logic wr_valid, wr_ready, lz_suppress, enable;
    logic [1:0] which;
    logic [7:0] seg;
    logic [23:0] wr_data_b;
    logic [5:0] wr_dp_b, blank_b, blink_b;
    logic wr_valid_b, wr_ready_b, lz_b, enable_b;
    logic [2:0] which_b;
    logic [7:0] seg_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_scan_display #(.N_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_dp(wr_dp), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .blank_mask(blank_mask), .blink_mask(blink_mask),
        .lz_suppress(lz_suppress), .enable(enable), .which(which), .seg(seg)
    );

    seg_scan_display #(.N_DIGITS(6), .SCAN_DIV(2), .BLINK_FRAMES(2)) dut_b (
        .clk(clk), .rst(rst2), .wr_data(wr_data_b), .wr_dp(wr_dp_b), .wr_valid(wr_valid_b),
        .wr_ready(wr_ready_b), .blank_mask(blank_b), .blink_mask(blink_b),
        .lz_suppress(lz_b), .enable(enable_b), .which(which_b), .seg(seg_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time since reset (k edges) alone determines digit, frame and blink phase.
    int k;
    int kb;
    logic m_init = 1'b0;
    logic m_live, m_pend;
    logic [15:0] m_disp, m_pdata;
    logic [3:0] m_dpd, m_pdp, l_blank, l_blink;
    logic l_lz;

    always @(posedge clk) begin
        if (rst) begin
            k <= 0;
            m_init <= 1'b1;
            m_live <= 1'b0;
            m_pend <= 1'b0;
            m_disp <= '0;
            m_dpd <= '0;
        end else begin
            k <= k + 1;
            m_live <= 1'b1;
            l_blank <= blank_mask;
            l_blink <= blink_mask;
            l_lz <= lz_suppress;
            if (m_pend && k % FR == FR - 1) begin
                m_disp <= m_pdata;
                m_dpd <= m_pdp;
                m_pend <= 1'b0;
            end else if (wr_valid && !m_pend) begin
                m_pdata <= wr_data;
                m_pdp <= wr_dp;
                m_pend <= 1'b1;
            end
        end
    end

    always @(posedge clk) kb <= rst2 ? 0 : kb + 1;

    function automatic void model_out(input int kk, input logic live, input logic [15:0] d,
                                      input logic [3:0] dp, input logic [3:0] bl, input logic [3:0] bk,
                                      input logic lz, output logic [1:0] w, output logic e,
                                      output logic [7:0] s);
        int dig;
        logic bp, hidden;
        logic [15:0] top;
        logic [7:0] g;
        dig = (kk / SD) % N;
        bp = ((kk / FR) / BF) % 2 == 1;
        top = d >> (4 * (N - 1 - dig));
        hidden = bl[dig] || (bk[dig] && bp) || (lz && dig < N - 1 && top == 16'h0);
        g = HEX[top[3:0]];
        g[0] = ~dp[dig];
        w = dig[1:0];
        e = live && !hidden;
        s = (!live || hidden) ? 8'hFF : g;
    endfunction

    always @(negedge clk) begin
        logic [1:0] ew;
        logic ee;
        logic [7:0] es;
        if (m_init) begin
            model_out(k, m_live, m_disp, m_dpd, l_blank, l_blink, l_lz, ew, ee, es);
            chk("model_which", {30'd0, which}, {30'd0, ew});
            chk("model_enable", {31'd0, enable}, {31'd0, ee});
            chk("model_seg", {24'd0, seg}, {24'd0, es});
            chk("model_ready", {31'd0, wr_ready}, {31'd0, !m_pend});
        end
    end

    task automatic wait_k(input int m, input int r);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (k % m == r) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_k: got timeout expected k%%%0d==%0d", m, r);
    endtask

    task automatic wait_kb(input int r);
        for (int n = 0; n < 100; n++) begin
            if (kb == r) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL wait_kb: got timeout expected kb==%0d", r);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        int n;
        n = 0;
        wr_data = d;
        wr_dp = p;
        wr_valid = 1'b1;
        while (!wr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("load_ready", {31'd0, wr_ready}, 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        wr_data = '0; wr_dp = '0; wr_valid = 1'b0;
        blank_mask = '0; blink_mask = '0; lz_suppress = 1'b0;
        wr_data_b = '0; wr_dp_b = '0; wr_valid_b = 1'b0;
        blank_b = '0; blink_b = '0; lz_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_enable", {31'd0, enable}, 32'd0);
        chk("rst_ready", {31'd0, wr_ready}, 32'd1);
        rst = 1'b0;
        // 1: plain scan of 12AF
        load(16'h12AF, 4'b0000);
        chk("t1_ready_low", {31'd0, wr_ready}, 32'd0);
        wait_k(FR, 0);
        chk("t1_which0", {30'd0, which}, 32'd0);
        chk("t1_seg0", {24'd0, seg}, 32'h9F);
        chk("t1_en0", {31'd0, enable}, 32'd1);
        repeat (4) @(negedge clk);
        chk("t1_which1", {30'd0, which}, 32'd1);
        chk("t1_seg1", {24'd0, seg}, 32'h25);
        repeat (4) @(negedge clk);
        chk("t1_seg2", {24'd0, seg}, 32'h11);
        repeat (4) @(negedge clk);
        chk("t1_which3", {30'd0, which}, 32'd3);
        chk("t1_seg3", {24'd0, seg}, 32'h71);
        // 2: leading-zero suppression
        lz_suppress = 1'b1;
        load(16'h0012, 4'b0000);
        wait_k(FR, 0);
        chk("t2_d0_en", {31'd0, enable}, 32'd0);
        chk("t2_d0_seg", {24'd0, seg}, 32'hFF);
        repeat (4) @(negedge clk);
        chk("t2_d1_en", {31'd0, enable}, 32'd0);
        repeat (4) @(negedge clk);
        chk("t2_d2_seg", {24'd0, seg}, 32'h9F);
        repeat (4) @(negedge clk);
        chk("t2_d3_seg", {24'd0, seg}, 32'h25);
        load(16'h0000, 4'b0000);
        wait_k(FR, 0);
        chk("t2_zero_d0_en", {31'd0, enable}, 32'd0);
        repeat (12) @(negedge clk);
        chk("t2_zero_d3_seg", {24'd0, seg}, 32'h03);
        chk("t2_zero_d3_en", {31'd0, enable}, 32'd1);
        // 3: mid-frame accept, held valid while not ready
        lz_suppress = 1'b0;
        wait_k(FR, 6);
        load(16'h1111, 4'b0000);
        wr_data = 16'h2222;
        wr_valid = 1'b1;
        chk("t3_ready_low", {31'd0, wr_ready}, 32'd0);
        wait_k(FR, 8);
        chk("t3_old_seg", {24'd0, seg}, 32'h03);
        wait_k(FR, FR - 1);
        chk("t3_ready_fe", {31'd0, wr_ready}, 32'd0);
        wr_valid = 1'b0;
        @(negedge clk);
        chk("t3_ready_back", {31'd0, wr_ready}, 32'd1);
        chk("t3_new_seg", {24'd0, seg}, 32'h9F);
        repeat (FR) @(negedge clk);
        chk("t3_no_2222", {24'd0, seg}, 32'h9F);
        // 4: accept on the frame_end edge
        wait_k(FR, FR - 1);
        load(16'h3456, 4'b0000);
        chk("t4_still_old", {24'd0, seg}, 32'h9F);
        chk("t4_pending", {31'd0, wr_ready}, 32'd0);
        repeat (FR) @(negedge clk);
        chk("t4_new_seg", {24'd0, seg}, 32'h0D);
        // 5: blink, blank and dp
        blink_mask = 4'b0001;
        wait_k(4 * FR, 2 * FR);
        chk("t5_blink_dark_en", {31'd0, enable}, 32'd0);
        chk("t5_blink_dark_seg", {24'd0, seg}, 32'hFF);
        wait_k(4 * FR, 0);
        chk("t5_blink_lit", {24'd0, seg}, 32'h0D);
        blink_mask = 4'b0000;
        load(16'h3456, 4'b0100);
        wait_k(FR, 0);
        blank_mask = 4'b0100;
        wait_k(FR, 8);
        chk("t5_blank_en", {31'd0, enable}, 32'd0);
        chk("t5_blank_seg", {24'd0, seg}, 32'hFF);
        blank_mask = 4'b0000;
        wait_k(FR, 8);
        chk("t5_dp_d2", {24'd0, seg}, 32'h48);
        load(16'h0000, 4'b0001);
        wait_k(FR, 0);
        chk("t5_dp_zero", {24'd0, seg}, 32'h02);
        // 6: six digits, fast scan, reset mid-handshake
        rst2 = 1'b0;
        @(negedge clk);
        wait_kb(11);
        chk("t6_which5", {29'd0, which_b}, 32'd5);
        @(negedge clk);
        chk("t6_wrap0", {29'd0, which_b}, 32'd0);
        chk("t6_seg0", {24'd0, seg_b}, 32'h03);
        wr_data_b = 24'h123456;
        wr_valid_b = 1'b1;
        @(negedge clk);
        wr_valid_b = 1'b0;
        chk("t6_accepted", {31'd0, wr_ready_b}, 32'd0);
        rst2 = 1'b1;
        @(negedge clk);
        chk("t6_rst_which", {29'd0, which_b}, 32'd0);
        chk("t6_rst_seg", {24'd0, seg_b}, 32'hFF);
        chk("t6_rst_en", {31'd0, enable_b}, 32'd0);
        chk("t6_rst_ready", {31'd0, wr_ready_b}, 32'd1);
        rst2 = 1'b0;
        @(negedge clk);
        wait_kb(12);
        chk("t6_pending_lost", {24'd0, seg_b}, 32'h03);
        chk("t6_ready_after", {31'd0, wr_ready_b}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
